// File: rtl/ifetch_pkg.sv
// Shared fetch-path definitions: RV32 opcodes, the canonical NOP word and the
// fetch FSM state type. The PC stage imports this package as well.
package ifetch_pkg;

  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_NOP    = 7'b0010011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifetch_imm_gen.sv
// Combinational opcode/immediate extraction for the control-flow instructions
// the PC stage needs an offset for (JAL, JALR, conditional branches).
module imm_gen
  import ifetch_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [6:0]         OP,
  output logic signed [31:0] up_amt
);

  assign OP = instr[6:0];

  always_comb begin
    up_amt = '0;
    case (instr[6:0])
      OP_JAL:    up_amt = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      OP_JALR:   up_amt = {{20{instr[31]}}, instr[31:20]};
      OP_BRANCH: up_amt = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      default:   up_amt = '0;
    endcase
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: issues one memory request at a time, captures the
// returned word with its address, and hands opcode/offset back to the PC stage.
module ifetch
  import ifetch_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        IP,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_rvalid,
  input  logic               stall_in,
  input  logic               flush,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc_out,
  output logic [6:0]         OP,
  output logic signed [31:0] up_amt
);

  fetch_state_e       state_q, state_d;
  logic               discard_q, discard_d;
  logic               req_q, req_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [31:0]        pc_q, pc_d;
  logic [6:0]         op_q, op_d;
  logic signed [31:0] up_amt_q, up_amt_d;

  logic [6:0]         gen_op;
  logic signed [31:0] gen_imm;

  // Decode the next instruction so OP/up_amt register on the same edge as instr.
  imm_gen u_imm_gen (
    .instr  (instr_d),
    .OP     (gen_op),
    .up_amt (gen_imm)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    pc_d      = pc_q;

    if (flush) begin
      // A response arriving with the flush retires the old request, so only
      // an unanswered request leaves a stale response to throw away later.
      discard_d = (state_q == REQ) && !imem_rvalid;
      instr_d   = NOP_INSTR;
      valid_d   = 1'b0;
      state_d   = REQ;
      req_d     = 1'b1;
      addr_d    = IP;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = IP;
        end
        REQ: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              addr_d    = IP;
            end else begin
              instr_d = imem_rdata;
              pc_d    = addr_q;
              valid_d = 1'b1;
              if (stall_in) begin
                state_d = HOLD;
                req_d   = 1'b0;
              end else begin
                addr_d = IP;
              end
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = IP;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      endcase
    end

    op_d     = valid_d ? gen_op  : OP_NOP;
    up_amt_d = valid_d ? gen_imm : '0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      discard_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op_q      <= OP_NOP;
      up_amt_q  <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      up_amt_q  <= up_amt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign OP          = op_q;
  assign up_amt      = up_amt_q;

endmodule
